// File: rtl/lcd_write_arbiter.sv
// rtl/lcd_write_arbiter.sv - burst-locked round-robin arbiter in front of the lcd_write serializer
//
// Purpose:
//   Shares one lcd_write SPI serializer between N_REQ requesters. Channel 0 is
//   the init sequencer and is the only eligible channel until init_done is high.
//   A grant is held for a whole burst (until the word flagged req_last has been
//   written), so command/data sequences of different requesters never interleave.
//   Optional watchdog (build macro LCD_ARB_WDOG_EN) aborts a burst when
//   lcd_wr_done does not arrive within WD_CYCLES clocks.
//
// Ports:
//   clk         system clock
//   rst         asynchronous active-high reset
//   init_done   LCD init complete; while low only channel 0 may be granted
//   req         per-channel request, held high for the whole burst
//   req_data    flattened request words, channel i at [i*DATA_W +: DATA_W]
//   req_last    current word of channel i is the last of its burst
//   grant       one-hot owner of the serializer
//   req_ack     1-cycle pulse: current word of the owner has been written
//   lcd_data    word presented to lcd_write
//   lcd_en      1-cycle write strobe to lcd_write
//   lcd_wr_done 1-cycle completion pulse from lcd_write
//   busy        high whenever the arbiter is not idle
//   wd_err      1-cycle pulse on watchdog abort (constant 0 without the macro)

module lcd_write_arbiter #(
   parameter int N_REQ     = 3,
   parameter int DATA_W    = 9,
   parameter int WD_CYCLES = 4096
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    init_done,
   input  logic [N_REQ-1:0]        req,
   input  logic [N_REQ*DATA_W-1:0] req_data,
   input  logic [N_REQ-1:0]        req_last,
   output logic [N_REQ-1:0]        grant,
   output logic [N_REQ-1:0]        req_ack,
   output logic [DATA_W-1:0]       lcd_data,
   output logic                    lcd_en,
   input  logic                    lcd_wr_done,
   output logic                    busy,
   output logic                    wd_err
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

   state_t            state, state_nxt;
   logic [PW-1:0]     rr_ptr;     // last-served channel
   logic [PW-1:0]     gidx;       // index of the current owner
   logic [PW-1:0]     pick;
   logic              pick_vld;
   logic [N_REQ-1:0]  eligible;
   logic              last_q;
   logic              wd_expire;

   assign eligible = req & (init_done ? {N_REQ{1'b1}} : {{(N_REQ-1){1'b0}}, 1'b1});

   // Round-robin search starting just after the last-served channel.
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      for (int k = 1; k <= N_REQ; k++) begin
         if (!pick_vld && eligible[(int'(rr_ptr) + k) % N_REQ]) begin
            pick     = PW'((int'(rr_ptr) + k) % N_REQ);
            pick_vld = 1'b1;
         end
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Next-state logic; a completion pulse takes priority over watchdog expiry.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:  if (pick_vld) state_nxt = ISSUE;
         ISSUE: state_nxt = req[gidx] ? WAIT : IDLE;
         WAIT: begin
            if (lcd_wr_done)    state_nxt = last_q ? IDLE : HOLD;
            else if (wd_expire) state_nxt = IDLE;
         end
         HOLD:  state_nxt = ISSUE;
         default: state_nxt = IDLE;
      endcase
   end

   // Combinational outputs
   always_comb begin
      busy = (state != IDLE);
   end

   // Registered outputs and burst bookkeeping
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant    <= '0;
         req_ack  <= '0;
         lcd_data <= '0;
         lcd_en   <= 1'b0;
         last_q   <= 1'b0;
         gidx     <= '0;
         rr_ptr   <= '0;
      end else begin
         req_ack <= '0;
         lcd_en  <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  grant <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                  gidx  <= pick;
               end
            end
            ISSUE: begin
               if (!req[gidx]) begin
                  // requester abandoned the burst before its word went out
                  grant  <= '0;
                  rr_ptr <= gidx;
               end else begin
                  lcd_data <= req_data[int'(gidx)*DATA_W +: DATA_W];
                  last_q   <= req_last[gidx];
                  lcd_en   <= 1'b1;
               end
            end
            WAIT: begin
               if (lcd_wr_done) begin
                  req_ack <= grant;
                  if (last_q) begin
                     grant  <= '0;
                     rr_ptr <= gidx;
                  end
               end else if (wd_expire) begin
                  // ack lets the requester unwind; rest of the burst is dropped
                  req_ack <= grant;
                  grant   <= '0;
                  rr_ptr  <= gidx;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef LCD_ARB_WDOG_EN
   localparam int CW = $clog2(WD_CYCLES + 1);

   logic [CW-1:0] wd_cnt;

   // wd_cnt counts completed WAIT cycles; expiry fires in the WD_CYCLES-th one.
   assign wd_expire = (state == WAIT) && (wd_cnt == CW'(WD_CYCLES - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt <= '0;
         wd_err <= 1'b0;
      end else begin
         wd_err <= (state == WAIT) && !lcd_wr_done && wd_expire;
         if (state == ISSUE)
            wd_cnt <= '0;
         else if (state == WAIT && !wd_expire)
            wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_expire = 1'b0;
   assign wd_err    = 1'b0;
`endif

endmodule

// File: tb/tb_lcd_write_arbiter.sv
// tb/tb_lcd_write_arbiter.sv - self-checking bench for lcd_write_arbiter

module tb_lcd_write_arbiter;

   localparam int N = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          init_done = 1'b0;
   logic [N-1:0]  req = '0;
   logic [N*9-1:0] req_data = '0;
   logic [N-1:0]  req_last = '0;
   logic [N-1:0]  grant, req_ack;
   logic [8:0]    lcd_data;
   logic          lcd_en, busy, wd_err;
   logic          lcd_wr_done = 1'b0;

   lcd_write_arbiter #(.N_REQ(N), .DATA_W(9), .WD_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .init_done(init_done), .req(req), .req_data(req_data),
      .req_last(req_last), .grant(grant), .req_ack(req_ack), .lcd_data(lcd_data),
      .lcd_en(lcd_en), .lcd_wr_done(lcd_wr_done), .busy(busy), .wd_err(wd_err)
   );

   always #5 clk = ~clk;

   // requester word queues: {last, data[8:0]}
   logic [9:0] q [N][$];
   bit         hold_req [N];
   int         n_assert = 0, n_fail = 0;
   int         cyc = 0, last_en = -100, en_cyc = 0;
   int         owner = -1, last_served = 0, abandon_ch = -1;
   bit         abandon_pend = 0, waiting = 0, wd_allowed = 0;
   int         done_cnt = 0, lat_force = 0;
   int         n_en = 0, n_wd = 0, zero_run = 0, ack2_at_g1 = -1;
   int         n_ack [N];
   int         gseq [$];
   int         gaps [$];
   logic [8:0] en_data = '0;
   logic [N-1:0] grant_prev = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] onehot(input int i);
      if (i < 0) return '0;
      return N'(1 << i);
   endfunction

   // Reference arbitration: first eligible channel after the last served one.
   function automatic int model_pick(input logic [N-1:0] r, input logic ini, input int last);
      int c;
      for (int k = 1; k <= N; k++) begin
         c = (last + k) % N;
         if (r[c] && (ini || c == 0)) return c;
      end
      return -1;
   endfunction

   task automatic tick();
      logic         done_prev;
      logic [N-1:0] exp_ack;
      bit           acked_last;
      int           pk;
      @(negedge clk);
      cyc++;
      done_prev   = lcd_wr_done;
      lcd_wr_done = 1'b0;
      acked_last  = 0;
      chk("busy", busy, |grant);
`ifdef LCD_ARB_WDOG_EN
      if (wd_err) n_wd++;
      if (!wd_allowed) chk("wd_err_quiet", wd_err, 0);
`else
      chk("wd_err_off", wd_err, 0);
`endif
      exp_ack = ((done_prev && waiting) || wd_err) ? onehot(owner) : '0;
      chk("req_ack", req_ack, exp_ack);
      for (int i = 0; i < N; i++) begin
         if (req_ack[i] && q[i].size() > 0) begin
            acked_last = q[i][0][9];
            void'(q[i].pop_front());
            n_ack[i]++;
         end
      end
      if (req_ack != 0 || wd_err) begin
         waiting  = 0;
         done_cnt = 0;
      end
      if (grant_prev == 0) begin
         pk = model_pick(req, init_done, last_served);
         chk("grant_pick", grant, onehot(pk));
         if (grant != 0) begin
            owner = pk;
            gseq.push_back(pk);
            gaps.push_back(zero_run);
            zero_run = 0;
            if (pk == 1) ack2_at_g1 = n_ack[2];
            if (pk == abandon_ch) begin
               hold_req[pk] = 0;
               q[pk].delete();
               abandon_pend = 1;
               abandon_ch   = -1;
            end
         end
      end else begin
         if (acked_last || abandon_pend || wd_err) begin
            chk("grant_drop", grant, 0);
            last_served = owner;
         end else begin
            chk("grant_hold", grant, grant_prev);
         end
         abandon_pend = 0;
      end
      if (grant == 0) zero_run++;
      if (lcd_en) begin
         chk("en_owner", grant, onehot(owner));
         if (owner >= 0 && q[owner].size() > 0) chk("en_data", lcd_data, q[owner][0][8:0]);
         else chk("en_unexpected", 1, 0);
         chk("en_gap", (cyc - last_en) >= 3, 1);
         last_en  = cyc;
         en_cyc   = cyc;
         en_data  = lcd_data;
         n_en++;
         waiting  = 1;
         done_cnt = (lat_force != 0) ? lat_force : $urandom_range(1, 4);
      end else if (waiting) begin
         chk("data_hold", lcd_data, en_data);
      end
      if (done_cnt > 0) begin
         done_cnt--;
         if (done_cnt == 0) lcd_wr_done = 1'b1;
      end
      for (int i = 0; i < N; i++) begin
         req[i] = hold_req[i] && (q[i].size() > 0);
         req_data[i*9 +: 9] = (q[i].size() > 0) ? q[i][0][8:0] : 9'($urandom);
         req_last[i] = (q[i].size() > 0) ? q[i][0][9] : 1'($urandom);
      end
      grant_prev = grant;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      lcd_wr_done = 1'b0;
      req = '0;
      for (int i = 0; i < N; i++) begin
         q[i].delete();
         hold_req[i] = 1;
         n_ack[i] = 0;
      end
      done_cnt = 0; waiting = 0; owner = -1; last_served = 0; grant_prev = '0;
      abandon_pend = 0; abandon_ch = -1; last_en = -100; zero_run = 0;
      n_en = 0; n_wd = 0; ack2_at_g1 = -1;
      gseq.delete();
      gaps.delete();
      repeat (2) @(negedge clk);
      chk("rst_grant", grant, 0);
      chk("rst_ack", req_ack, 0);
      chk("rst_en", lcd_en, 0);
      chk("rst_data", lcd_data, 0);
      chk("rst_busy", busy, 0);
      chk("rst_wd", wd_err, 0);
      rst = 1'b0;
   endtask

   function automatic bit all_empty();
      return q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0;
   endfunction

   initial begin
      // init gating: only ch0 may be served while init_done is low
      do_reset();
      init_done = 1'b0;
      q[0].push_back(10'h011);
      q[0].push_back(10'h129);
      q[0].push_back(10'h3FF);
      q[1].push_back({1'b1, 9'($urandom)});
      q[2].push_back({1'b1, 9'($urandom)});
      for (int n = 0; n < 200 && n_ack[0] < 3; n++) tick();
      repeat (10) tick();
      chk("init_ch0_acks", n_ack[0], 3);
      chk("init_en_count", n_en, 3);
      chk("init_grants", gseq.size(), 1);
      init_done = 1'b1;
      for (int n = 0; n < 200 && !all_empty(); n++) tick();
      chk("init_drain", all_empty(), 1);
      chk("init_order1", gseq.size() > 1 ? gseq[1] : -1, 1);
      chk("init_order2", gseq.size() > 2 ? gseq[2] : -1, 2);

      // round robin with continuous single-word requests
      do_reset();
      init_done = 1'b1;
      for (int i = 0; i < N; i++)
         repeat (3) q[i].push_back({1'b1, 9'($urandom)});
      for (int n = 0; n < 500 && !all_empty(); n++) tick();
      chk("rr_drain", all_empty(), 1);
      chk("rr_g0", gseq.size() > 0 ? gseq[0] : -1, 1);
      chk("rr_g1", gseq.size() > 1 ? gseq[1] : -1, 2);
      chk("rr_g2", gseq.size() > 2 ? gseq[2] : -1, 0);
      chk("rr_g3", gseq.size() > 3 ? gseq[3] : -1, 1);
      for (int k = 1; k < 4; k++) chk("rr_gap", gaps.size() > k ? gaps[k] : -1, 1);

      // burst lock: ch2 four-word burst, ch1 requests after word 1
      do_reset();
      init_done = 1'b1;
      for (int k = 0; k < 4; k++) q[2].push_back({(k == 3), 9'($urandom)});
      q[1].push_back({1'b1, 9'($urandom)});
      hold_req[1] = 0;
      for (int n = 0; n < 100 && n_ack[2] < 1; n++) tick();
      hold_req[1] = 1;
      for (int n = 0; n < 300 && !all_empty(); n++) tick();
      chk("lock_drain", all_empty(), 1);
      chk("lock_acks2", n_ack[2], 4);
      chk("lock_acks2_before_g1", ack2_at_g1, 4);

      // abandon: ch1 drops req while in ISSUE
      do_reset();
      init_done = 1'b1;
      abandon_ch = 1;
      q[1].push_back({1'b0, 9'h055});
      q[1].push_back({1'b1, 9'h0AA});
      q[2].push_back({1'b1, 9'($urandom)});
      for (int n = 0; n < 100 && q[2].size() != 0; n++) tick();
      repeat (3) tick();
      chk("abandon_en_count", n_en, 1);
      chk("abandon_first", gseq.size() > 0 ? gseq[0] : -1, 1);
      chk("abandon_next", gseq.size() > 1 ? gseq[1] : -1, 2);

      // spurious completion in IDLE
      do_reset();
      init_done = 1'b1;
      repeat (2) tick();
      lcd_wr_done = 1'b1;
      tick();
      chk("spur_ack", req_ack, 0);
      tick();
      chk("spur_busy", busy, 0);

`ifdef LCD_ARB_WDOG_EN
      wd_allowed = 1;
      lat_force  = 1000;
      q[1].push_back({1'b1, 9'($urandom)});
      for (int n = 0; n < 50 && n_en < 1; n++) tick();
      for (int n = 0; n < 100 && !wd_err; n++) tick();
      chk("wd_fired", wd_err, 1);
      chk("wd_delay", cyc - en_cyc, 16);
      tick();
      chk("wd_grant_clear", grant, 0);
      lat_force = 16;
      q[2].push_back({1'b1, 9'($urandom)});
      for (int n = 0; n < 100 && n_ack[2] < 1; n++) tick();
      repeat (3) tick();
      chk("wd_edge_ack", n_ack[2], 1);
      chk("wd_edge_count", n_wd, 1);
      wd_allowed = 0;
`else
      lat_force = 40;
      q[1].push_back({1'b1, 9'($urandom)});
      for (int n = 0; n < 100 && n_ack[1] < 1; n++) tick();
      chk("long_wait_ack", n_ack[1], 1);
`endif
      lat_force = 0;

      // asynchronous reset while ch1 word 2 is in WAIT
      do_reset();
      init_done = 1'b1;
      lat_force = 6;
      q[1].push_back({1'b0, 9'h0F1});
      q[1].push_back({1'b0, 9'h1E2});
      q[1].push_back({1'b1, 9'h0D3});
      for (int n = 0; n < 100 && !(n_ack[1] == 1 && waiting); n++) tick();
      chk("mid_busy", busy, 1);
      #2 rst = 1'b1;
      #1;
      chk("async_grant", grant, 0);
      chk("async_data", lcd_data, 0);
      chk("async_busy", busy, 0);
      chk("async_en", lcd_en, 0);
      chk("async_ack", req_ack, 0);
      lat_force = 0;
      do_reset();
      for (int i = 0; i < N; i++) q[i].push_back({1'b1, 9'($urandom)});
      for (int n = 0; n < 200 && !all_empty(); n++) tick();
      chk("post_rst_first", gseq.size() > 0 ? gseq[0] : -1, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/lcd_write_arbiter.md
Name: lcd_write_arbiter

Overview:
- Shares the single lcd_write SPI serializer (9-bit word, en_write/wr_done handshake) between N_REQ requesters: init sequencer, picture streamer and UART text path.
- Grants the serializer for whole bursts, so no requester can interleave into another's command/data sequence.
- Uses round-robin arbitration.
- Blocks all requesters except channel 0 (init) until init_done is high.
- Sits between the requesters and lcd_write, and replaces the static mux in the control path.

Parameters:
- N_REQ, 3: number of requesters. Channel 0 is the init channel.
- DATA_W, 9: word width ({dc, byte[7:0]}).
- WD_CYCLES, 4096: watchdog limit in clk cycles while waiting for lcd_wr_done. Used only with LCD_ARB_WDOG_EN.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- init_done  in  1  LCD init complete. While low, only channel 0 is eligible.
- req  in  N_REQ  per-channel request; held high for the whole burst
- req_data  in  N_REQ*DATA_W  flattened words; channel i at [i*DATA_W +: DATA_W]
- req_last  in  N_REQ  current word is the last word of the burst
- grant  out  N_REQ  one-hot owner of the serializer
- req_ack  out  N_REQ  1-cycle pulse: current word accepted by the serializer
- lcd_data  out  DATA_W  word to lcd_write
- lcd_en  out  1  1-cycle write strobe to lcd_write
- lcd_wr_done  in  1  1-cycle completion pulse from lcd_write
- busy  out  1  high whenever state is not IDLE
- wd_err  out  1  1-cycle pulse on watchdog abort. Tied 0 when the macro is off.

Behaviour:
- Reset (async, rst=1) forces:
  - state=IDLE
  - grant=0, req_ack=0, lcd_en=0, lcd_data=0, busy=0, wd_err=0
  - rr_ptr=0 (rr_ptr is the last-served channel)
- States: IDLE, ISSUE, WAIT, HOLD.
- IDLE:
  - eligible = req & (init_done ? all-ones : one-hot(0)).
  - If eligible is nonzero: pick the first set bit searching from rr_ptr+1 mod N_REQ upward. Register grant, go to ISSUE.
  - Grant appears 1 cycle after req is sampled.
- ISSUE:
  - If req[g] is low, the requester has abandoned the burst: clear grant, set rr_ptr=g, go to IDLE. No write is issued.
  - Otherwise: lcd_data <= req_data[g], latch last_q <= req_last[g], pulse lcd_en for exactly 1 cycle, go to WAIT.
  - First lcd_en occurs 2 cycles after req is sampled in IDLE.
- WAIT:
  - On lcd_wr_done: pulse req_ack[g].
    - If last_q=1: clear grant, rr_ptr=g, go to IDLE.
    - Otherwise go to HOLD.
  - lcd_data holds its value throughout WAIT.
- HOLD:
  - One dead cycle. The requester advances req_data/req_last on the edge after req_ack.
  - Next state: ISSUE, which samples the new word.
- Word cadence: lcd_en pulses are at least 3 cycles apart (ISSUE→WAIT→HOLD→ISSUE, with WAIT lasting at least 1 cycle).
- lcd_wr_done outside WAIT: ignored, with no effect on state or outputs.
- Simultaneous lcd_wr_done and watchdog expiry: lcd_wr_done wins; normal completion, no wd_err.
- Changes to req/req_data from non-granted channels during a burst: ignored.
- A burst started on channel 0 before init_done rises completes normally.
- init_done falling mid-burst does not abort the current burst. It only masks eligibility at the next IDLE.
- A single-word burst (req_last=1 on the first word) is legal.
- The grant of a just-finished channel drops to 0 for at least one IDLE cycle before any new grant.
- Round-robin fairness: with all channels requesting continuously, the order is 1,2,0,1,2,...
  - After reset, rr_ptr=0, so channel 1 wins first when init_done=1.
- Mid-operation reset: immediate return to reset values. The in-flight SPI word is abandoned; lcd_write is reset by the same system reset.

Optional Feature:
- Macro: LCD_ARB_WDOG_EN.
- Defined:
  - A cycle counter runs in WAIT and clears on entry to WAIT.
  - When the counter reaches WD_CYCLES with no lcd_wr_done: pulse wd_err 1 cycle and pulse req_ack[g] 1 cycle so the requester can unwind.
  - Then clear grant, set rr_ptr=g and go to IDLE. The rest of the burst is dropped.
- Undefined:
  - No counter is built, wd_err is tied 0, and WAIT waits indefinitely for lcd_wr_done.

Test Plan:
- Init gating: init_done=0; req=3'b111; ch0 burst of 3 words 0x011, 0x129, 0x1FF with last on word 3.
  - Expect exactly 3 lcd_en pulses carrying those data values, all with grant=001.
  - ch1 and ch2 get no grant until init_done=1.
- Round robin: init_done=1; all three channels make continuous 1-word requests.
  - Expect grant order 010, 100, 001, 010.
  - Expect grant=0 for one cycle between grants.
- Burst lock: ch2 holds a 4-word burst; ch1 raises req after word 1.
  - Expect all 4 ch2 words before any ch1 grant.
  - Expect 4 req_ack[2] pulses.
- Abandon: ch1 granted, then ch1 drops req before ISSUE.
  - Expect no lcd_en, grant returns to 0, and next arbitration starts from ch2.
- Spurious and simultaneous events: lcd_wr_done pulsed in IDLE gives no req_ack.
  - With LCD_ARB_WDOG_EN and WD_CYCLES=16: withhold lcd_wr_done → wd_err pulse 16 cycles after entering WAIT, grant cleared.
  - lcd_wr_done on cycle 16 exactly → normal ack, no wd_err.
- Reset mid-burst: assert rst during WAIT of ch1 word 2.
  - Expect all outputs 0 asynchronously.
  - After release, arbitration restarts with rr_ptr=0.
